// File: rtl/jpeg_entropy_sequencer.sv
// Entropy-segment byte front end: strips 0xFF00 stuffing and fill bytes, parses RSTn/EOI markers,
// and sequences the downstream bit buffer (forward, flush on restart, end-of-image pulse).
module jpeg_entropy_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        img_start_i,
    input  logic        inport_valid_i,
    input  logic [7:0]  inport_data_i,
    input  logic        inport_last_i,
    output logic        inport_accept_o,
    output logic        bb_valid_o,
    output logic [7:0]  bb_data_o,
    input  logic        bb_accept_i,
    output logic        bb_flush_o,
    output logic        bb_last_o,
    output logic        rst_pending_o,
    input  logic        rst_ack_i,
    output logic        eoi_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] rst_count_o
);

    typedef enum logic [2:0] {
        S_DATA,
        S_FF_SEEN,
        S_RST_WAIT,
        S_RST_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_bb_valid;
    logic [7:0]  r_bb_data;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_rst_count;
    logic [2:0]  r_exp_idx;
    logic        r_last_sent;

    logic        w_out_free;
    logic        w_take;
    logic        w_is_rst;
    logic        w_load;
    logic [7:0]  w_load_data;
    logic        w_set_err;
    logic [1:0]  w_err_code;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_DATA;
        end else if (img_start_i) begin
            r_state <= S_DATA;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_out_free      = !r_bb_valid || bb_accept_i;
        w_is_rst        = (inport_data_i[7:3] == 5'b11010);
        inport_accept_o = (((r_state == S_DATA) || (r_state == S_FF_SEEN)) && w_out_free)
                          || (r_state == S_ERROR);
        w_take          = inport_valid_i && inport_accept_o;

        w_state_next    = r_state;
        w_load          = 1'b0;
        w_load_data     = inport_data_i;
        w_set_err       = 1'b0;
        w_err_code      = 2'd0;

        bb_flush_o      = (r_state == S_RST_FLUSH);
        rst_pending_o   = (r_state == S_RST_WAIT);
        eoi_o           = (r_state == S_DONE);
        bb_last_o       = (r_state == S_DONE) && !r_bb_valid && !r_last_sent;

        case (r_state)
            S_DATA: begin
                if (w_take) begin
                    if (inport_data_i == 8'hFF) begin
                        // A segment that ends on a lone 0xFF can never be paired.
                        if (inport_last_i) begin
                            w_set_err    = 1'b1;
                            w_err_code   = 2'd3;
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_FF_SEEN;
                        end
                    end else begin
                        w_load = 1'b1;
                        if (inport_last_i) begin
                            w_state_next = S_DONE;
                        end
                    end
                end
            end
            S_FF_SEEN: begin
                if (w_take) begin
                    if (inport_data_i == 8'h00) begin
                        w_load       = 1'b1;
                        w_load_data  = 8'hFF;
                        w_state_next = inport_last_i ? S_DONE : S_DATA;
                    end else if (inport_data_i == 8'hFF) begin
                        if (inport_last_i) begin
                            w_set_err    = 1'b1;
                            w_err_code   = 2'd3;
                            w_state_next = S_DONE;
                        end
                    end else if (w_is_rst) begin
                        // Out-of-sequence restart index is flagged but the restart still proceeds.
                        if (inport_data_i[2:0] != r_exp_idx) begin
                            w_set_err  = 1'b1;
                            w_err_code = 2'd1;
                        end
                        w_state_next = S_RST_WAIT;
                    end else if (inport_data_i == 8'hD9) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_set_err    = 1'b1;
                        w_err_code   = 2'd2;
                        w_state_next = S_ERROR;
                    end
                end
            end
            S_RST_WAIT: begin
                if (!r_bb_valid && rst_ack_i) begin
                    w_state_next = S_RST_FLUSH;
                end
            end
            S_RST_FLUSH: begin
                w_state_next = S_DATA;
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bb_valid  <= 1'b0;
            r_bb_data   <= 8'h00;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_rst_count <= 16'd0;
            r_exp_idx   <= 3'd0;
            r_last_sent <= 1'b0;
        end else if (img_start_i) begin
            r_bb_valid  <= 1'b0;
            r_bb_data   <= 8'h00;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_rst_count <= 16'd0;
            r_exp_idx   <= 3'd0;
            r_last_sent <= 1'b0;
        end else begin
            if (w_load) begin
                r_bb_valid <= 1'b1;
                r_bb_data  <= w_load_data;
            end else if (bb_accept_i) begin
                r_bb_valid <= 1'b0;
            end
            // Only the first error's code is kept; the flag is sticky until the next image.
            if (w_set_err && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
            if (r_state == S_RST_FLUSH) begin
                r_exp_idx   <= r_exp_idx + 3'd1;
                r_rst_count <= r_rst_count + 16'd1;
            end
            if (bb_last_o) begin
                r_last_sent <= 1'b1;
            end
        end
    end

    assign bb_valid_o  = r_bb_valid;
    assign bb_data_o   = r_bb_data;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;
    assign rst_count_o = r_rst_count;

endmodule
